// File: rtl/ysyx_lsu_wb_if.sv
// Bundle of the EXU-side input, memory request/response bus and register-file
// write port for ysyx_lsu_wb. The LSU uses the slave view; the surrounding
// environment (EXU, memory, regfile) uses the master view.
interface ysyx_lsu_wb_if #(
  parameter int XLEN = 32
);
  // EXU -> LSU
  logic            in_valid;
  logic            in_ready;
  logic            in_is_load;
  logic            in_is_store;
  logic [2:0]      in_funct3;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_store_data;
  // memory bus
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;
  // register file write port and status
  logic            rf_wr_en;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            done;
  logic            misalign;

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_rd,
           in_alu_result, in_addr, in_store_data,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen,
           mem_req_wdata, mem_req_wstrb, rf_wr_en, rf_waddr, rf_wdata,
           done, misalign
  );

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_rd,
           in_alu_result, in_addr, in_store_data,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen,
           mem_req_wdata, mem_req_wstrb, rf_wr_en, rf_waddr, rf_wdata,
           done, misalign
  );
endinterface

// File: rtl/ysyx_lsu_wb.sv
// Load/store + writeback stage feeding the register file.
// One instruction in flight: IDLE accepts, REQ issues the memory request,
// WAIT collects the response, WB pulses the register write and done.
// Optional macro YSYX_LSU_MISALIGN_CHK_EN: when defined, misaligned
// half/word accesses skip memory and retire with a misalign pulse.
module ysyx_lsu_wb #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  ysyx_lsu_wb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t          state;
  logic            in_ready_q;
  logic            mem_req_valid_q;
  logic            mem_req_wen_q;
  logic [XLEN-1:0] mem_req_addr_q;
  logic [XLEN-1:0] mem_req_wdata_q;
  logic [3:0]      mem_req_wstrb_q;
  logic            rf_wr_en_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            done_q;
  logic            misalign_q;

  // fields latched at acceptance, used when the response returns
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic            is_load_q;

  // byte enables for a store; loads never reach this
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  store_strb = 4'b0001 << a;
      3'b001:  store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // replicate the store operand across every lane it may land in
  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  store_data = {4{d[7:0]}};
      3'b001:  store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // select the addressed lane of the read word and sign/zero extend it
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                   input logic [XLEN-1:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = XLEN'(b);
      3'b100:  load_extract = XLEN'($unsigned(b));
      3'b001:  load_extract = XLEN'(h);
      3'b101:  load_extract = XLEN'($unsigned(h));
      default: load_extract = w;
    endcase
  endfunction

`ifdef YSYX_LSU_MISALIGN_CHK_EN
  // halves need addr[0]==0, words and reserved widths need addr[1:0]==0
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = a[0];
      default:        is_misaligned = (a != 2'b00);
    endcase
  endfunction
`endif

  // decode of the incoming instruction; load wins when both flags are set
  logic in_mem;
  logic in_store;
  logic in_mis;

  assign in_mem   = bus.in_is_load | bus.in_is_store;
  assign in_store = bus.in_is_store & ~bus.in_is_load;
`ifdef YSYX_LSU_MISALIGN_CHK_EN
  assign in_mis   = in_mem & is_misaligned(bus.in_funct3, bus.in_addr[1:0]);
`else
  assign in_mis   = 1'b0;
`endif

  // control FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_wen_q   <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= '0;
      rf_wr_en_q      <= 1'b0;
      rf_waddr_q      <= '0;
      rf_wdata_q      <= '0;
      done_q          <= 1'b0;
      misalign_q      <= 1'b0;
      rd_q            <= '0;
      funct3_q        <= '0;
      addr_lo_q       <= '0;
      is_load_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            rd_q       <= bus.in_rd;
            funct3_q   <= bus.in_funct3;
            addr_lo_q  <= bus.in_addr[1:0];
            is_load_q  <= bus.in_is_load;
            rf_waddr_q <= bus.in_rd;
            if (in_mis) begin
              state      <= WB;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
              rf_wr_en_q <= 1'b0;
            end else if (in_mem) begin
              state           <= REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {bus.in_addr[XLEN-1:2], 2'b00};
              mem_req_wen_q   <= in_store;
              mem_req_wdata_q <= in_store ? store_data(bus.in_funct3, bus.in_store_data) : '0;
              mem_req_wstrb_q <= in_store ? store_strb(bus.in_funct3, bus.in_addr[1:0]) : 4'b0000;
            end else begin
              state      <= WB;
              done_q     <= 1'b1;
              rf_wr_en_q <= (bus.in_rd != 5'd0);
              rf_wdata_q <= bus.in_alu_result;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state  <= WB;
            done_q <= 1'b1;
            if (is_load_q) begin
              rf_wr_en_q <= (rd_q != 5'd0);
              rf_wdata_q <= load_extract(funct3_q, addr_lo_q, bus.mem_resp_rdata);
            end else begin
              rf_wr_en_q <= 1'b0;
            end
          end
        end
        WB: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
          done_q     <= 1'b0;
          rf_wr_en_q <= 1'b0;
          misalign_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wen   = mem_req_wen_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_wstrb = mem_req_wstrb_q;
  assign bus.rf_wr_en      = rf_wr_en_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.done          = done_q;
  assign bus.misalign      = misalign_q;

endmodule

// File: tb/tb_ysyx_lsu_wb.sv
// Scoreboard bench for ysyx_lsu_wb: directed instructions push expected
// memory requests and writebacks; a negedge monitor pops and compares.
module tb_ysyx_lsu_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_lsu_wb_if #(.XLEN(32)) bus();
  ysyx_lsu_wb #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    int          cyc;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  wb_t  exp_q[$];
  req_t req_q[$];
  wb_t  mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model controls, written only by the stimulus process
  int          ready_delay = 0;
  logic        no_resp = 1'b0;
  logic [31:0] resp_data = 32'h0;
  int          stray_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic wb_t mk_wb(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic mis, input int lat);
    wb_t w;
    w.we = we; w.waddr = wa; w.wdata = wd; w.mis = mis; w.cyc = lat;
    return w;
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                                  input logic [3:0] s);
    req_t r;
    r.addr = a; r.wen = wen; r.wdata = wd; r.wstrb = s;
    return r;
  endfunction

  // memory responder: ready after ready_delay cycles, response right after handshake
  int wait_cnt = 0;
  int stray_done = 0;
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      if (stray_req != stray_done) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hFFFF_FFFF;
        stray_done = stray_req;
      end else if (bus.mem_req_ready) begin
        bus.mem_req_ready = 1'b0;
        if (!no_resp) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = resp_data;
        end
      end else if (bus.mem_req_valid) begin
        if (wait_cnt >= ready_delay) begin
          bus.mem_req_ready = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // monitor: request fields compared every cycle valid is high, writeback on done
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("req_addr", bus.mem_req_addr, req_q[0].addr);
          chk("req_wen", 32'(bus.mem_req_wen), 32'(req_q[0].wen));
          chk("req_wstrb", 32'(bus.mem_req_wstrb), 32'(req_q[0].wstrb));
          if (req_q[0].wen) chk("req_wdata", bus.mem_req_wdata, req_q[0].wdata);
          if (bus.mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(mon_e.we));
          chk("misalign", 32'(bus.misalign), 32'(mon_e.mis));
          if (mon_e.we) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.waddr));
            chk("rf_wdata", bus.rf_wdata, mon_e.wdata);
          end
        end
      end else begin
        if (bus.rf_wr_en) chk("wr_en_without_done", 32'd1, 32'd0);
        if (bus.misalign) chk("misalign_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] addr, input logic [31:0] sd,
                       input wb_t w, input logic has_req, input req_t r, input logic [31:0] rdata);
    int n = 0;
    wb_t e;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    e = w;
    e.cyc = cyc + w.cyc;
    exp_q.push_back(e);
    if (has_req) req_q.push_back(r);
    resp_data         = rdata;
    bus.in_valid      = 1'b1;
    bus.in_is_load    = ld;
    bus.in_is_store   = st;
    bus.in_funct3     = f3;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
    bus.in_addr       = addr;
    bus.in_store_data = sd;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_is_load  = 1'b0;
    bus.in_is_store = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || !bus.in_ready) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_is_store   = 1'b0;
    bus.in_funct3     = 3'b000;
    bus.in_rd         = 5'd0;
    bus.in_alu_result = 32'h0;
    bus.in_addr       = 32'h0;
    bus.in_store_data = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("reset_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_misalign", 32'(bus.misalign), 32'd0);
    chk("reset_wstrb", 32'(bus.mem_req_wstrb), 32'd0);

    // ALU ops: retire one cycle after acceptance
    issue(1'b0, 1'b0, 3'b000, 5'd5, 32'h1234_5678, 32'h0, 32'h0,
          mk_wb(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1), 1'b0, mk_req(0, 0, 0, 0), 32'h0);
    drain();
    issue(1'b0, 1'b0, 3'b000, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0,
          mk_wb(1'b0, 5'd0, 32'h0, 1'b0, 1), 1'b0, mk_req(0, 0, 0, 0), 32'h0);
    drain();

    // LB / LBU of lane 3 = 0x80
    issue(1'b1, 1'b0, 3'b000, 5'd7, 32'h0, 32'h8000_0003, 32'h0,
          mk_wb(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000), 32'h80FF_0011);
    drain();
    issue(1'b1, 1'b0, 3'b100, 5'd7, 32'h0, 32'h8000_0003, 32'h0,
          mk_wb(1'b1, 5'd7, 32'h0000_0080, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000), 32'h80FF_0011);
    drain();

    // SH to upper half with ready held off 3 cycles
    ready_delay = 3;
    issue(1'b0, 1'b1, 3'b001, 5'd9, 32'h0, 32'h8000_0002, 32'h0000_BEEF,
          mk_wb(1'b0, 5'd9, 32'h0, 1'b0, 6), 1'b1,
          mk_req(32'h8000_0000, 1'b1, 32'hBEEF_BEEF, 4'b1100), 32'h0);
    drain();
    ready_delay = 0;

    // SB lane 1, SW
    issue(1'b0, 1'b1, 3'b000, 5'd3, 32'h0, 32'h8000_0001, 32'h1234_56A5,
          mk_wb(1'b0, 5'd3, 32'h0, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0010), 32'h0);
    drain();
    issue(1'b0, 1'b1, 3'b010, 5'd4, 32'h0, 32'h8000_0010, 32'hCAFE_F00D,
          mk_wb(1'b0, 5'd4, 32'h0, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0010, 1'b1, 32'hCAFE_F00D, 4'b1111), 32'h0);
    drain();

    // LH upper half sign-extended, LHU lower half, LW
    issue(1'b1, 1'b0, 3'b001, 5'd10, 32'h0, 32'h8000_0002, 32'h0,
          mk_wb(1'b1, 5'd10, 32'hFFFF_8001, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000), 32'h8001_7FFF);
    drain();
    issue(1'b1, 1'b0, 3'b101, 5'd11, 32'h0, 32'h8000_0000, 32'h0,
          mk_wb(1'b1, 5'd11, 32'h0000_7FFF, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000), 32'h8001_7FFF);
    drain();
    issue(1'b1, 1'b0, 3'b010, 5'd31, 32'h0, 32'h8000_0004, 32'h0,
          mk_wb(1'b1, 5'd31, 32'h0123_4567, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0004, 1'b0, 32'h0, 4'b0000), 32'h0123_4567);
    drain();

    // load and store flags together behave as a load
    issue(1'b1, 1'b1, 3'b010, 5'd12, 32'h0, 32'h8000_0008, 32'hFFFF_FFFF,
          mk_wb(1'b1, 5'd12, 32'h55AA_55AA, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0008, 1'b0, 32'h0, 4'b0000), 32'h55AA_55AA);
    drain();

    // misaligned LW
`ifdef YSYX_LSU_MISALIGN_CHK_EN
    issue(1'b1, 1'b0, 3'b010, 5'd13, 32'h0, 32'h8000_0002, 32'h0,
          mk_wb(1'b0, 5'd13, 32'h0, 1'b1, 1), 1'b0, mk_req(0, 0, 0, 0), 32'h1111_2222);
`else
    issue(1'b1, 1'b0, 3'b010, 5'd13, 32'h0, 32'h8000_0002, 32'h0,
          mk_wb(1'b1, 5'd13, 32'h1111_2222, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000), 32'h1111_2222);
`endif
    drain();

    // reset while waiting for a response, then a stray response in IDLE
    no_resp = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 5'd14, 32'h0, 32'h8000_0020, 32'h0,
          mk_wb(1'b1, 5'd14, 32'h0, 1'b0, 3), 1'b1,
          mk_req(32'h8000_0020, 1'b0, 32'h0, 4'b0000), 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    req_q.delete();
    no_resp = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    stray_req++;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("stray_in_ready", 32'(bus.in_ready), 32'd1);
    chk("stray_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);

    // still functional afterwards
    issue(1'b0, 1'b0, 3'b000, 5'd1, 32'hA5A5_0001, 32'h0, 32'h0,
          mk_wb(1'b1, 5'd1, 32'hA5A5_0001, 1'b0, 1), 1'b0, mk_req(0, 0, 0, 0), 32'h0);
    drain();

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
